// File: rtl/ontransit_pkg.sv
// Shared types for the on-transit sequencer consumer stages.
// Holds the burst-counter FSM state encoding, the default burst entry
// layout and the default counter width.
package ontransit_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] len;
    logic                 ovf;
  } burst_entry_t;

endpackage

// File: rtl/ontransit_fifo2.sv
// Two-entry register FIFO. The head entry always sits in e0, so the
// head output is a plain register with no read mux. A push into a full
// FIFO is ignored unless a pop happens in the same cycle.
module ontransit_fifo2 #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;
  logic [1:0]        cnt;

  assign head  = e0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  // Shift-register storage: pop moves e1 into e0, push fills the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            e0  <= din;
            cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            e0 <= din;
          end else if (push) begin
            e1  <= din;
            cnt <= 2'd2;
          end else if (pop) begin
            e0  <= '0;
            cnt <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            e0 <= e1;
            if (push) begin
              e1 <= din;
            end else begin
              e1  <= '0;
              cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ontransit_burst_counter.sv
// Burst-length counter behind the on-transit grant/step sequencer.
// Counts step pulses (s) during a run and, on the closing grant (g),
// queues {length, overflow} into a two-entry buffer read out through a
// valid/ready handshake. A closed burst that finds the buffer full is
// discarded and flagged with a one-cycle drop pulse.
// Optional: define ONTRANSIT_BURST_TIMEOUT_EN to force-close a burst
// after TIMEOUT_CYC step-free cycles (entry marked with ovf=1).
module ontransit_burst_counter
  import ontransit_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             g,
  output logic [CNT_W-1:0] len,
  output logic             len_ovf,
  output logic             len_vld,
  input  logic             len_rdy,
  output logic             drop,
  output logic             busy
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  // Saturating increment; the MSB reports that the input was already at max.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return {1'b1, v};
    else    return {1'b0, v + 1'b1};
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r;
  logic [CNT_W-1:0] inc_val;
  logic             inc_hit;
  logic             push_req;
  logic [CNT_W-1:0] push_len;
  logic             push_ovf;
  logic             timeout;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W:0]   fifo_head;

  assign {inc_hit, inc_val} = sat_inc(cnt);

`ifdef ONTRANSIT_BURST_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout = (state == ACC) && !s && !g &&
                   (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  // Step-free cycle counter, live only while accumulating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != ACC) || s || g || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Entry to queue this cycle; a step coinciding with g belongs to the closing burst.
  always_comb begin
    push_req = 1'b0;
    push_len = '0;
    push_ovf = 1'b0;
    case (state)
      IDLE: begin
        if (g) begin
          push_req = 1'b1;
          push_len = s ? CNT_W'(1) : '0;
        end
      end
      ACC: begin
        if (g) begin
          push_req = 1'b1;
          push_len = s ? inc_val : cnt;
          push_ovf = ovf_r | (s & inc_hit);
        end else if (timeout) begin
          push_req = 1'b1;
          push_len = cnt;
          push_ovf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Run tracking FSM: open on the first step, close on g (or timeout).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s && !g) begin
            state <= ACC;
            cnt   <= CNT_W'(1);
            ovf_r <= 1'b0;
          end
        end
        ACC: begin
          if (g || timeout) begin
            state <= IDLE;
            cnt   <= '0;
            ovf_r <= 1'b0;
          end else if (s) begin
            cnt   <= inc_val;
            ovf_r <= ovf_r | inc_hit;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          ovf_r <= 1'b0;
        end
      endcase
    end
  end

  assign pop = len_vld && len_rdy;

  // Discard flag: a close that finds the buffer full with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else begin
      drop <= push_req && fifo_full && !pop;
    end
  end

  ontransit_fifo2 #(
    .DATA_W(CNT_W + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_req),
    .din  ({push_ovf, push_len}),
    .pop  (pop),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign len     = fifo_head[CNT_W-1:0];
  assign len_ovf = fifo_head[CNT_W];
  assign len_vld = !fifo_empty;
  assign busy    = (state == ACC);

endmodule

// File: tb/tb_ontransit_burst_counter.sv
// Directed bench for ontransit_burst_counter: a default-width instance
// (CNT_W=8, TIMEOUT_CYC=8) and a narrow instance (CNT_W=4) for saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point, i.e. they reflect the edge just taken.
module tb_ontransit_burst_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s, g, len_rdy;
  logic [7:0] len;
  logic       len_ovf, len_vld, drop, busy;

  logic       s4, g4, rdy4;
  logic [3:0] len4;
  logic       ovf4, vld4, drop4, busy4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ontransit_burst_counter #(.CNT_W(8), .TIMEOUT_CYC(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .s(s), .g(g),
    .len(len), .len_ovf(len_ovf), .len_vld(len_vld), .len_rdy(len_rdy),
    .drop(drop), .busy(busy)
  );

  ontransit_burst_counter #(.CNT_W(4), .TIMEOUT_CYC(64)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s(s4), .g(g4),
    .len(len4), .len_ovf(ovf4), .len_vld(vld4), .len_rdy(rdy4),
    .drop(drop4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic steps(input int n);
    s = 1'b1;
    for (int i = 0; i < n; i++) tick();
    s = 1'b0;
  endtask

  task automatic close();
    g = 1'b1;
    tick();
    g = 1'b0;
  endtask

  initial begin
    s = 0; g = 0; len_rdy = 0; s4 = 0; g4 = 0; rdy4 = 0;
    rst_n = 1'b0;
    idle(2);
    chk("rst_len", len, 0);
    chk("rst_ovf", len_ovf, 0);
    chk("rst_vld", len_vld, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    // 3 steps then g
    steps(3);
    chk("t1_busy", busy, 1);
    chk("t1_vld_pre", len_vld, 0);
    close();
    chk("t1_vld", len_vld, 1);
    chk("t1_len", len, 3);
    chk("t1_ovf", len_ovf, 0);
    chk("t1_busy_after", busy, 0);
    len_rdy = 1'b1;
    tick();
    chk("t1_pop", len_vld, 0);
    tick();
    chk("empty_rdy", len_vld, 0);
    len_rdy = 1'b0;
    idle(1);

    // zero-length run
    close();
    chk("t2_vld", len_vld, 1);
    chk("t2_len", len, 0);
    chk("t2_ovf", len_ovf, 0);
    len_rdy = 1'b1;
    tick();
    len_rdy = 1'b0;
    chk("t2_pop", len_vld, 0);
    idle(2);

    // saturation on the narrow instance: 17 steps then g
    s4 = 1'b1;
    idle(17);
    s4 = 1'b0;
    g4 = 1'b1;
    tick();
    g4 = 1'b0;
    chk("t3_len", len4, 15);
    chk("t3_ovf", ovf4, 1);
    chk("t3_vld", vld4, 1);

    // overflow of the buffer: bursts 1, 2, 3 with len_rdy low
    steps(1); close(); idle(2);
    steps(2); close(); idle(2);
    steps(3);
    chk("t4_nodrop", drop, 0);
    close();
    chk("t4_drop", drop, 1);
    tick();
    chk("t4_drop_clr", drop, 0);
    chk("t4_head1", len, 1);
    len_rdy = 1'b1;
    tick();
    chk("t4_vld2", len_vld, 1);
    chk("t4_head2", len, 2);
    tick();
    chk("t4_empty", len_vld, 0);
    len_rdy = 1'b0;
    idle(1);

    // full buffer with push and pop in the same cycle
    steps(1); close(); idle(2);
    steps(2); close(); idle(2);
    steps(3);
    g = 1'b1; len_rdy = 1'b1;
    tick();
    g = 1'b0;
    chk("t5_nodrop", drop, 0);
    chk("t5_head2", len, 2);
    tick();
    chk("t5_vld3", len_vld, 1);
    chk("t5_head3", len, 3);
    tick();
    chk("t5_empty", len_vld, 0);
    len_rdy = 1'b0;
    idle(2);

    // s and g together: from ACC with cnt=2, then from IDLE
    steps(2);
    s = 1'b1; g = 1'b1;
    tick();
    s = 1'b0; g = 1'b0;
    chk("sg_acc_len", len, 3);
    chk("sg_acc_busy", busy, 0);
    len_rdy = 1'b1; tick(); len_rdy = 1'b0;
    idle(2);
    s = 1'b1; g = 1'b1;
    tick();
    s = 1'b0; g = 1'b0;
    chk("sg_idle_len", len, 1);
    chk("sg_idle_busy", busy, 0);
    len_rdy = 1'b1; tick(); len_rdy = 1'b0;
    idle(2);

    // reset mid-burst with a buffered entry
    steps(1); close(); idle(2);
    steps(5);
    chk("t6_vld_pre", len_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_len", len, 0);
    chk("t6_vld", len_vld, 0);
    chk("t6_busy", busy, 0);
    chk("t6_drop", drop, 0);
    chk("t6_len4", len4, 0);
    tick();
    rst_n = 1'b1;
    idle(1);
    steps(2);
    close();
    chk("t6_post_len", len, 2);
    chk("t6_post_ovf", len_ovf, 0);
    len_rdy = 1'b1; tick(); len_rdy = 1'b0;
    idle(2);

`ifdef ONTRANSIT_BURST_TIMEOUT_EN
    // 4 steps then silence: forced close 8 cycles after the last step
    steps(4);
    idle(7);
    chk("to_busy_hold", busy, 1);
    chk("to_vld_hold", len_vld, 0);
    tick();
    chk("to_busy", busy, 0);
    chk("to_vld", len_vld, 1);
    chk("to_len", len, 4);
    chk("to_ovf", len_ovf, 1);
`else
    // no timeout: a long silence keeps the burst open
    steps(1);
    idle(70);
    chk("nto_busy", busy, 1);
    chk("nto_vld", len_vld, 0);
    close();
    chk("nto_len", len, 1);
    chk("nto_ovf", len_ovf, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ontransit_burst_counter.md
Name: ontransit_burst_counter

Overview:
- Downstream consumer of the on-transit grant/step sequencer.
- Counts the one-cycle step pulses (s) that occur during a run. On the closing grant pulse (g), it packages the burst length plus an overflow flag into an entry.
- Entries go into a 2-entry buffer with a valid/ready handshake toward the length consumer.
- Gives the datapath a per-burst beat count without needing to know the upstream sequencer timing.

Parameters:
- CNT_W, 8, width of the burst-length counter and of the len output.
- TIMEOUT_CYC, 64, idle cycles in ACC before a forced close. Used only when ONTRANSIT_BURST_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s  input  1  step pulse from the sequencer (registered upstream, one cycle per beat)
- g  input  1  grant/close pulse from the sequencer (one cycle, ends the burst)
- len  output  CNT_W  burst length of the head entry
- len_ovf  output  1  head entry saturated (true count exceeded 2^CNT_W-1)
- len_vld  output  1  head entry valid
- len_rdy  input  1  consumer accepts the head entry when len_vld && len_rdy
- drop  output  1  registered one-cycle pulse: a closed burst was discarded because the buffer was full
- busy  output  1  state == ACC

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE, cnt 0, ovf flag 0, buffer empty.
  - len 0, len_ovf 0, len_vld 0, drop 0, busy 0.
  - Reset mid-burst discards the partial count and all buffered entries.
- FSM states: IDLE, ACC.
  - IDLE, s: cnt <= 1, go to ACC.
  - IDLE, g: push entry {len=0, ovf=0}, stay in IDLE. This is a zero-length run: the sequencer went RUN then LAST with no steps.
  - IDLE, neither: hold.
  - ACC, s: cnt <= cnt+1, saturating at 2^CNT_W-1. Any increment attempted at max sets the ovf flag.
  - ACC, g: push {cnt, ovf}, clear cnt and ovf, go to IDLE.
- s and g in the same cycle (protocol violation): the step is counted into the closing burst. Pushed length is cnt+1 (saturating), or 1 from IDLE.
- Push timing: the entry is written at the clock edge ending the g cycle.
  - If the buffer was empty, len_vld rises the next cycle.
  - Latency from g to len_vld is 1 cycle.
- Buffer: 2 entries, FIFO order. len, len_ovf and len_vld come from the head register, not from combinational logic on the inputs.
- Pop: occurs at the edge when len_vld && len_rdy are both 1.
- Full buffer, push and pop in the same cycle: both happen and no drop occurs.
- Full buffer, push without pop: the entry is discarded, the counter still clears, and drop pulses high for exactly 1 cycle (the cycle after g).
- Empty buffer with len_rdy high: no effect.
- A back-to-back burst needs no wait state. The upstream sequencer guarantees at least 2 idle cycles between g and the next s.

Optional Feature:
- Macro: ONTRANSIT_BURST_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ACC and resets on every s.
  - When it reaches TIMEOUT_CYC with no s or g, the burst closes as if g arrived: push {cnt, ovf=1}, then go to IDLE.
  - ovf=1 marks an aborted burst.
  - The idle counter is cleared in IDLE and on reset.
- Not defined: ACC waits indefinitely for g and the idle counter logic is absent.

Decomposition:
- Shared package ontransit_pkg:
  - state enum (IDLE, ACC)
  - burst entry struct (len[CNT_W], ovf)
  - default CNT_W constant
- Sub-module ontransit_fifo2: 2-entry register FIFO with push, pop, full, empty, and head outputs. It is instantiated once and is reusable by other on-transit stages.

Test Plan:
- s pulses on 3 consecutive cycles, then g → one entry, len=3, len_ovf=0, len_vld high the cycle after g; len_rdy=1 pops it.
- g alone from IDLE → entry len=0, len_ovf=0.
- CNT_W=4, 17 s pulses then g → len=15, len_ovf=1.
- len_rdy=0, three bursts of lengths 1, 2, 3 → first two are buffered; the third causes drop=1 for 1 cycle. With len_rdy then raised, outputs appear in order 1, 2.
- Buffer full, with g and len_vld && len_rdy in the same cycle → no drop; next outputs are 2, then the new burst.
- rst_n low mid-burst after 5 s pulses → all outputs 0 immediately; a following 2-step burst reports len=2.
- With ONTRANSIT_BURST_TIMEOUT_EN and TIMEOUT_CYC=8: 4 s pulses then silence → entry len=4, len_ovf=1 and busy=0, 8 cycles after the last s.
